// File: rtl/prefix_adder.sv
// Kogge-Stone parallel-prefix adder with carry-in/carry-out and a single
// output register. {Cout,Sum} = A + B + Cin, one cycle after the operands
// are sampled; a new operand set is accepted on every clock.
module prefix_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  // Cin occupies prefix position 0 and operand bit i occupies position i+1,
  // so the tree spans N+1 positions. Cout must see all of them, including
  // Cin, which needs $clog2(N+1) levels. With only $clog2(N) levels a
  // power-of-two N would drop Cin from the carry out of the top bit.
  localparam int LVLS = $clog2(N + 1);

  // Group generate/propagate after each level; index 0 is the pre-processed
  // input and index LVLS is the final prefix result.
  logic [N:0] gen_l [LVLS+1];
  logic [N:0] prp_l [LVLS+1];

  logic [N-1:0] p_bit;
  logic [N-1:0] sum_c;
  logic         cout_c;

  // Prefix tree: combine each node with the node d positions below it.
  // Nodes with no partner at distance d pass through, so every node is
  // driven for any N, powers of two or not.
  always_comb begin
    p_bit    = A ^ B;
    gen_l[0] = {A & B, Cin};
    prp_l[0] = {p_bit, 1'b0};
    for (int l = 0; l < LVLS; l++) begin
      for (int j = 0; j <= N; j++) begin
        if (j >= (1 << l)) begin
          gen_l[l+1][j] = gen_l[l][j] | (prp_l[l][j] & gen_l[l][j-(1<<l)]);
          prp_l[l+1][j] = prp_l[l][j] & prp_l[l][j-(1<<l)];
        end else begin
          gen_l[l+1][j] = gen_l[l][j];
          prp_l[l+1][j] = prp_l[l][j];
        end
      end
    end
  end

  // Post-process: the carry into bit i is the group generate of everything
  // below it, which sits at prefix position i.
  always_comb begin
    sum_c  = p_bit ^ gen_l[LVLS][N-1:0];
    cout_c = gen_l[LVLS][N];
  end

  // ---- stage boundary: output register ----
  // Result register; reset clears the result and wins over any operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
    end else begin
      Sum  <= sum_c;
      Cout <= cout_c;
    end
  end

endmodule

// File: tb/tb_prefix_adder.sv
// Bench for prefix_adder: four instances (N = 8, 16, 32, 64) share one clock,
// reset and a 64-bit operand bus truncated per width.
module tb_prefix_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_bus;
  logic [63:0] b_bus;
  logic        cin;

  logic [7:0]  s8;
  logic [15:0] s16;
  logic [31:0] s32;
  logic [63:0] s64;
  logic        c8, c16, c32, c64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prefix_adder #(.N(8))  u_add8  (.clk(clk), .rst(rst), .A(a_bus[7:0]),  .B(b_bus[7:0]),  .Cin(cin), .Sum(s8),  .Cout(c8));
  prefix_adder #(.N(16)) u_add16 (.clk(clk), .rst(rst), .A(a_bus[15:0]), .B(b_bus[15:0]), .Cin(cin), .Sum(s16), .Cout(c16));
  prefix_adder #(.N(32)) u_add32 (.clk(clk), .rst(rst), .A(a_bus[31:0]), .B(b_bus[31:0]), .Cin(cin), .Sum(s32), .Cout(c32));
  prefix_adder #(.N(64)) u_add64 (.clk(clk), .rst(rst), .A(a_bus),       .B(b_bus),       .Cin(cin), .Sum(s64), .Cout(c64));

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cout,sum}=%h expected %h", tag, obs, exp);
    end
  endtask

  // (w+1)-bit golden sum of the operands truncated to w bits.
  function automatic logic [64:0] golden(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic c);
    logic [64:0] m;
    m = (w == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << w) - 65'd1);
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {64'd0, c};
  endfunction

  // Compare all four widths; N=8/16 against hand values, N=32/64 against the model.
  task automatic check_all(input string tag, input logic [64:0] e8, input logic [64:0] e16,
                           input logic [63:0] a, input logic [63:0] b, input logic c);
    check({tag, "/8"},  {56'd0, c8,  s8},  e8);
    check({tag, "/16"}, {48'd0, c16, s16}, e16);
    check({tag, "/32"}, {32'd0, c32, s32}, golden(32, a, b, c));
    check({tag, "/64"}, {c64, s64},        golden(64, a, b, c));
  endtask

  // Drive one operand set, clock it in, and check one cycle later.
  task automatic vec(input string tag, input logic [63:0] a, input logic [63:0] b,
                     input logic c, input logic [64:0] e8, input logic [64:0] e16);
    @(negedge clk);
    a_bus = a; b_bus = b; cin = c;
    @(posedge clk);
    #1;
    check_all(tag, e8, e16, a, b, c);
  endtask

  logic [63:0] pa, pb;
  logic        pc;
  logic [63:0] ones;

  initial begin
    ones  = {64{1'b1}};
    rst   = 1'b1;
    a_bus = 64'h1234_5678_9ABC_DEF0;
    b_bus = 64'h0FED_CBA9_8765_4321;
    cin   = 1'b1;

    // Reset state with nonzero operands present.
    @(posedge clk); #1;
    check_all("reset", 65'd0, 65'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    vec("add65",     64'h65,   64'h65,   1'b0, 65'h0CA,   65'h000CA);
    vec("ones_b0",   ones,     64'd0,    1'b0, 65'h0FF,   65'h0FFFF);
    vec("ones_cin",  ones,     64'd0,    1'b1, 65'h100,   65'h10000);
    vec("ff_plus1",  64'hFF,   64'h01,   1'b0, 65'h100,   65'h00100);
    vec("fe_1_cin",  64'hFE,   64'h01,   1'b1, 65'h100,   65'h00100);
    vec("a5_5a",     64'hA5A5, 64'h5A5A, 1'b0, 65'h0FF,   65'h0FFFF);
    vec("aa_55",     64'hAA,   64'h55,   1'b0, 65'h0FF,   65'h000FF);
    vec("7f_1_cin",  64'h7F,   64'h01,   1'b1, 65'h081,   65'h00081);
    vec("10_20",     64'h10,   64'h20,   1'b0, 65'h030,   65'h00030);
    vec("max_max",   ones,     ones,     1'b1, 65'h1FF,   65'h1FFFF);
    vec("zero",      64'd0,    64'd0,    1'b0, 65'h000,   65'h00000);

    // Back-to-back random operands, one set per cycle.
    pa = a_bus; pb = b_bus; pc = cin;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i > 0) check_all("b2b", golden(8, pa, pb, pc), golden(16, pa, pb, pc), pa, pb, pc);
      pa = {$urandom, $urandom};
      pb = (i % 7 == 0) ? ~pa : {$urandom, $urandom};
      pc = 1'($urandom_range(0, 1));
      a_bus = pa; b_bus = pb; cin = pc;
    end
    @(negedge clk);
    check_all("b2b_last", golden(8, pa, pb, pc), golden(16, pa, pb, pc), pa, pb, pc);

    // Reset asserted mid-stream overrides nonzero operands.
    a_bus = 64'hDEAD_BEEF_CAFE_F00D;
    b_bus = 64'h0123_4567_89AB_CDEF;
    cin   = 1'b1;
    rst   = 1'b1;
    @(posedge clk); #1;
    check_all("mid_rst", 65'd0, 65'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    // 0D+EF+1 = 0xFD; F00D+CDEF+1 = 0x1BDFD
    check_all("post_rst", 65'h0FD, 65'h1BDFD, a_bus, b_bus, cin);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
